// File: rtl/router_pkt_reg_pkg.sv
// Shared constants for the router packet register: default byte width and
// the header address field layout.
package router_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
endpackage

// File: rtl/router_pkt_reg_parity_acc.sv
// Running XOR accumulator over the bytes of one packet.
// Only built when ROUTER_PARITY_CHECK_EN is defined.
module router_parity_acc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] byte_i,
  output logic [DATA_WIDTH-1:0] parity_o
);
  logic [DATA_WIDTH-1:0] parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (clear_i)       parity_d = '0;
    else if (enable_i) parity_d = parity_q ^ byte_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) parity_q <= '0;
    else       parity_q <= parity_d;
  end

  assign parity_o = parity_q;
endmodule

// File: rtl/router_pkt_reg.sv
// Router packet register: header/hold/output byte staging and parity tracking.
// ROUTER_PARITY_CHECK_EN builds the internal parity accumulator and err; otherwise err is 0.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pkt_valid,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_packet_valid,
  output logic                  err
);
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
  logic                  parity_done_q, parity_done_d;
  logic                  lpv_q, lpv_d;
  logic                  parity_set;

  always_comb begin
    parity_set = (ld_state & ~fifo_full & ~pkt_valid) |
                 (laf_state & lpv_q & ~parity_done_q);

    header_d = header_q;
    if (detect_add && pkt_valid && (data_in[ADDR_W-1:0] != ADDR_INVALID))
      header_d = data_in;

    dout_d = dout_q;
    if (lfd_state)                   dout_d = header_q;
    else if (ld_state && !fifo_full) dout_d = data_in;
    else if (laf_state)              dout_d = hold_q;

    hold_d = hold_q;
    if (ld_state && fifo_full) hold_d = data_in;

    pkt_par_d = parity_set ? data_in : pkt_par_q;

    parity_done_d = parity_done_q;
    if (parity_set)      parity_done_d = 1'b1;
    else if (detect_add) parity_done_d = 1'b0;

    lpv_d = lpv_q;
    if (ld_state && !pkt_valid) lpv_d = 1'b1;
    else if (rst_int_reg)       lpv_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_q        <= '0;
      header_q      <= '0;
      hold_q        <= '0;
      pkt_par_q     <= '0;
      parity_done_q <= 1'b0;
      lpv_q         <= 1'b0;
    end else begin
      dout_q        <= dout_d;
      header_q      <= header_d;
      hold_q        <= hold_d;
      pkt_par_q     <= pkt_par_d;
      parity_done_q <= parity_done_d;
      lpv_q         <= lpv_d;
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_WIDTH-1:0] int_par;
  logic                  err_q, err_d;

  // Header comes from the register on lfd; payload bytes come straight off data_in.
  router_parity_acc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_acc (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (detect_add),
    .enable_i (lfd_state | (ld_state & pkt_valid & ~full_state)),
    .byte_i   (lfd_state ? header_q : data_in),
    .parity_o (int_par)
  );

  always_comb begin
    err_d = err_q;
    if (rst_int_reg && parity_done_q) err_d = (int_par != pkt_par_q);
    else if (detect_add)              err_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_full_state;
  assign unused_full_state = full_state;
  assign err = 1'b0;
`endif

  assign dout             = dout_q;
  assign parity_done      = parity_done_q;
  assign low_packet_valid = lpv_q;
endmodule
